// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the shared multicycle MIPS datapath
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap undecoded opcodes in TRAP(14).
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       WBSel,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic             isSigned,
    output logic [1:0]       PCSource,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount,
    output logic             Trap
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADDR  = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_RWB      = 4'd7;
    localparam logic [3:0] S_EXEC_I   = 4'd8;
    localparam logic [3:0] S_IWB      = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_JAL      = 4'd12;
    localparam logic [3:0] S_JR       = 4'd13;
`ifdef MC_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP     = 4'd14;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [3:0]       state, state_nx;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic             pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw, reg_write_raw;

    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        case (state)
            S_FETCH:    if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   state_nx = S_MEMADDR;
                    OP_RTYPE:       state_nx = (funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI: state_nx = S_EXEC_I;
                    OP_BEQ, OP_BNE: state_nx = S_BRANCH;
                    OP_J:           state_nx = S_JUMP;
                    OP_JAL:         state_nx = S_JAL;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_nx = S_TRAP;
`else
                        state_nx = S_FETCH;
                        retire   = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADDR:  state_nx = (op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_nx = S_MEMWB;
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_nx = S_FETCH;
                    retire   = 1'b1;
                end
            end
            S_EXEC_R:   state_nx = S_RWB;
            S_EXEC_I:   state_nx = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:     state_nx = S_TRAP;
`endif
            default:    state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            op_q  <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) op_q <= opcode;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        IorD          = 1'b0;
        RegDst        = 2'b00;
        WBSel         = 2'b00;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 4'b0000;
        isSigned      = 1'b1;
        PCSource      = 2'b00;
        case (state)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                ALUSrcB      = 2'b01;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE:   ALUSrcB = 2'b11;
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: begin
                mem_read_raw = 1'b1;
                IorD         = 1'b1;
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                WBSel         = 2'b01;
            end
            S_MEMWRITE: begin
                mem_write_raw = 1'b1;
                IorD          = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 4'b0010;
            end
            S_RWB: begin
                reg_write_raw = 1'b1;
                RegDst        = 2'b01;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (op_q)
                    OP_SLTI:  ALUOp = 4'b0011;
                    OP_SLTIU: ALUOp = 4'b1000;
                    OP_ANDI:  begin ALUOp = 4'b0100; isSigned = 1'b0; end
                    OP_ORI:   begin ALUOp = 4'b0101; isSigned = 1'b0; end
                    OP_XORI:  begin ALUOp = 4'b0110; isSigned = 1'b0; end
                    OP_LUI:   begin ALUOp = 4'b0111; isSigned = 1'b0; end
                    default:  ALUOp = 4'b0000;
                endcase
            end
            S_IWB:      reg_write_raw = 1'b1;
            S_BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 4'b0001;
                PCSource     = 2'b01;
                pc_write_raw = (op_q == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_write_raw = 1'b1;
                PCSource     = 2'b10;
            end
            // Register file takes PC (already PC+4) on the same edge the PC loads the target.
            S_JAL: begin
                pc_write_raw  = 1'b1;
                PCSource      = 2'b10;
                reg_write_raw = 1'b1;
                RegDst        = 2'b10;
                WBSel         = 2'b10;
            end
            S_JR: begin
                pc_write_raw = 1'b1;
                PCSource     = 2'b11;
            end
            default: ;
        endcase
    end

    // Architectural-state strobes must be quiet for the whole reset assertion.
    assign PCWrite    = pc_write_raw  & rst_n;
    assign IRWrite    = ir_write_raw  & rst_n;
    assign MemRead    = mem_read_raw  & rst_n;
    assign MemWrite   = mem_write_raw & rst_n;
    assign RegWrite   = reg_write_raw & rst_n;
    assign State      = state;
    assign InstrCount = cnt_q;

`ifdef MC_ILLEGAL_TRAP_EN
    assign Trap = (state == S_TRAP);
`else
    assign Trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ready;
    logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite;
    logic [1:0]  RegDst, WBSel, ALUSrcB, PCSource;
    logic        ALUSrcA, isSigned, Trap;
    logic [3:0]  ALUOp, State;
    logic [31:0] InstrCount;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .WBSel(WBSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .isSigned(isSigned), .PCSource(PCSource), .State(State),
        .InstrCount(InstrCount), .Trap(Trap)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input int pcw, irw, iord, mr, mw, rw, rd, wb,
                                       input int a, b, op, s, ps);
        return {1'(pcw), 1'(irw), 1'(iord), 1'(mr), 1'(mw), 1'(rw), 2'(rd), 2'(wb),
                1'(a), 2'(b), 4'(op), 1'(s), 2'(ps)};
    endfunction

    //                                     pcw irw iord mr mw rw rd wb a  b  op s  ps
    localparam logic [19:0] C_RST  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    localparam logic [19:0] C_F1   = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    localparam logic [19:0] C_F0   = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    localparam logic [19:0] C_DEC  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    localparam logic [19:0] C_MA   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0);
    localparam logic [19:0] C_MR   = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    localparam logic [19:0] C_MWB  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
    localparam logic [19:0] C_MW   = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    localparam logic [19:0] C_EXR  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0);
    localparam logic [19:0] C_RWB  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
    localparam logic [19:0] C_ANDI = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4, 0, 0);
    localparam logic [19:0] C_SLTI = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 1, 0);
    localparam logic [19:0] C_IWB  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    localparam logic [19:0] C_BEQ  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    localparam logic [19:0] C_BNE  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    localparam logic [19:0] C_J    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    localparam logic [19:0] C_JAL  = mk(1, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 1, 2);
    localparam logic [19:0] C_JR   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
`ifdef MC_ILLEGAL_TRAP_EN
    localparam logic [19:0] C_TRAP = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
`endif

    typedef struct packed {
        logic [3:0]  st;
        logic [19:0] ctl;
        logic [31:0] cnt;
        logic        trap;
    } exp_t;

    exp_t        sb[$];
    int          vecs = 0;
    int          fails = 0;
    logic [31:0] cnt = 0;

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [19:0] got;
            e   = sb.pop_front();
            got = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, WBSel,
                   ALUSrcA, ALUSrcB, ALUOp, isSigned, PCSource};
            vecs++;
            if (State !== e.st) begin
                fails++;
                $display("FAIL state vec%0d: got %0d want %0d", vecs, State, e.st);
            end
            if (got !== e.ctl) begin
                fails++;
                $display("FAIL ctl vec%0d st%0d: got %b want %b", vecs, e.st, got, e.ctl);
            end
            if (InstrCount !== e.cnt) begin
                fails++;
                $display("FAIL count vec%0d: got %0d want %0d", vecs, InstrCount, e.cnt);
            end
            if (Trap !== e.trap) begin
                fails++;
                $display("FAIL trap vec%0d: got %b want %b", vecs, Trap, e.trap);
            end
        end
    end

    task automatic step(input logic [3:0] st, input logic [19:0] ctl, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic rdy,
                        input logic ret, input logic trp);
        exp_t e;
        @(posedge clk);
        #1;
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = rdy;
        e.st = st; e.ctl = ctl; e.cnt = cnt; e.trap = trp;
        sb.push_back(e);
        if (ret) cnt = cnt + 1;
    endtask

    task automatic pulse_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        cnt       = 0;
        e.st = 4'd0; e.ctl = C_RST; e.cnt = 0; e.trap = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b0;
        #1;
        e.st = 4'd0; e.ctl = C_RST; e.cnt = 0; e.trap = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // R-type add
        step(0,  C_F1,  6'h00, 6'h20, 0, 1, 0, 0);
        step(1,  C_DEC, 6'h00, 6'h20, 0, 1, 0, 0);
        step(6,  C_EXR, 6'h00, 6'h20, 0, 1, 0, 0);
        step(7,  C_RWB, 6'h00, 6'h20, 0, 1, 1, 0);
        // lw with a stalled fetch and 3 stalled MEMREAD cycles
        step(0,  C_F0,  6'h23, 6'h00, 0, 0, 0, 0);
        step(0,  C_F1,  6'h23, 6'h00, 0, 1, 0, 0);
        step(1,  C_DEC, 6'h23, 6'h00, 0, 0, 0, 0);
        step(2,  C_MA,  6'h23, 6'h00, 0, 0, 0, 0);
        step(3,  C_MR,  6'h23, 6'h00, 0, 0, 0, 0);
        step(3,  C_MR,  6'h23, 6'h00, 0, 0, 0, 0);
        step(3,  C_MR,  6'h23, 6'h00, 0, 0, 0, 0);
        step(3,  C_MR,  6'h23, 6'h00, 0, 1, 0, 0);
        step(4,  C_MWB, 6'h23, 6'h00, 0, 1, 1, 0);
        // beq taken, bne not taken (zero=1 for both)
        step(0,  C_F1,  6'h04, 6'h00, 1, 1, 0, 0);
        step(1,  C_DEC, 6'h04, 6'h00, 1, 1, 0, 0);
        step(10, C_BEQ, 6'h04, 6'h00, 1, 1, 1, 0);
        step(0,  C_F1,  6'h05, 6'h00, 1, 1, 0, 0);
        step(1,  C_DEC, 6'h05, 6'h00, 1, 1, 0, 0);
        step(10, C_BNE, 6'h05, 6'h00, 1, 1, 1, 0);
        // jal, jr, j
        step(0,  C_F1,  6'h03, 6'h00, 0, 1, 0, 0);
        step(1,  C_DEC, 6'h03, 6'h00, 0, 1, 0, 0);
        step(12, C_JAL, 6'h03, 6'h00, 0, 1, 1, 0);
        step(0,  C_F1,  6'h00, 6'h08, 0, 1, 0, 0);
        step(1,  C_DEC, 6'h00, 6'h08, 0, 1, 0, 0);
        step(13, C_JR,  6'h00, 6'h08, 0, 1, 1, 0);
        step(0,  C_F1,  6'h02, 6'h00, 0, 1, 0, 0);
        step(1,  C_DEC, 6'h02, 6'h00, 0, 1, 0, 0);
        step(11, C_J,   6'h02, 6'h00, 0, 1, 1, 0);
        // andi (zero-extended) and slti (sign-extended)
        step(0,  C_F1,  6'h0C, 6'h00, 0, 1, 0, 0);
        step(1,  C_DEC, 6'h0C, 6'h00, 0, 1, 0, 0);
        step(8,  C_ANDI,6'h0C, 6'h00, 0, 1, 0, 0);
        step(9,  C_IWB, 6'h0C, 6'h00, 0, 1, 1, 0);
        step(0,  C_F1,  6'h0A, 6'h00, 0, 1, 0, 0);
        step(1,  C_DEC, 6'h0A, 6'h00, 0, 1, 0, 0);
        step(8,  C_SLTI,6'h0A, 6'h00, 0, 1, 0, 0);
        step(9,  C_IWB, 6'h0A, 6'h00, 0, 1, 1, 0);
        // sw with one stall, then a second sw interrupted by reset in MEMWRITE
        step(0,  C_F1,  6'h2B, 6'h00, 0, 1, 0, 0);
        step(1,  C_DEC, 6'h2B, 6'h00, 0, 1, 0, 0);
        step(2,  C_MA,  6'h2B, 6'h00, 0, 1, 0, 0);
        step(5,  C_MW,  6'h2B, 6'h00, 0, 0, 0, 0);
        step(5,  C_MW,  6'h2B, 6'h00, 0, 1, 1, 0);
        step(0,  C_F1,  6'h2B, 6'h00, 0, 1, 0, 0);
        step(1,  C_DEC, 6'h2B, 6'h00, 0, 1, 0, 0);
        step(2,  C_MA,  6'h2B, 6'h00, 0, 1, 0, 0);
        step(5,  C_MW,  6'h2B, 6'h00, 0, 0, 0, 0);
        pulse_reset();
        // undecoded opcode
        step(0,  C_F1,  6'h3F, 6'h00, 0, 1, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
        step(1,  C_DEC, 6'h3F, 6'h00, 0, 1, 0, 0);
        step(14, C_TRAP,6'h3F, 6'h00, 0, 1, 0, 1);
        step(14, C_TRAP,6'h00, 6'h20, 0, 1, 0, 1);
        pulse_reset();
`else
        step(1,  C_DEC, 6'h3F, 6'h00, 0, 1, 1, 0);
        step(0,  C_F0,  6'h3F, 6'h00, 0, 0, 0, 0);
`endif

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the shared multicycle MIPS datapath: one memory port, one ALU, IR/MDR/ALUOut registers.
- Decodes the same instruction subset as the single-cycle decoder: R-type, jr, j, jal, addi, slti, sltiu, andi, ori, xori, lui, lw, sw, beq, bne.
- Emits per-state datapath strobes, stalls on a memory ready handshake, and keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of InstrCount (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- RegWrite  out  1  register file write enable.
- RegDst  out  2  destination register: 00 = rt, 01 = rd, 10 = $31.
- WBSel  out  2  write-back data: 00 = ALUOut, 01 = MDR, 10 = PC.
- ALUSrcA  out  1  ALU operand A: 0 = PC, 1 = regA.
- ALUSrcB  out  2  ALU operand B: 00 = regB, 01 = 4, 10 = imm, 11 = imm<<2.
- ALUOp  out  4  ALU operation code.
- isSigned  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- PCSource  out  2  next PC: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = regA.
- State  out  4  current state encoding, for debug.
- InstrCount  out  CNT_W  retired instruction count.
- Trap  out  1  illegal opcode flag; see Optional Feature.

Behaviour:
- ALUOp encodings:
  - 0000 add
  - 0001 sub
  - 0010 funct-decoded
  - 0011 slt
  - 1000 sltu
  - 0100 and
  - 0101 or
  - 0110 xor
  - 0111 lui
- Unlisted outputs are 0 in every state. isSigned defaults to 1.
- Reset (rst_n low, asynchronous):
  - State = FETCH(0), op_q = 0, InstrCount = 0, Trap = 0.
  - PCWrite, IRWrite, MemRead, MemWrite and RegWrite are forced 0 while rst_n is low.
  - An in-flight memory access is abandoned.
- FETCH(0):
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0000, PCSource=00.
  - If mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold in FETCH.
- DECODE(1):
  - ALUSrcA=0, ALUSrcB=11, ALUOp=0000 (branch target into ALUOut).
  - Latch opcode into op_q; all later states use op_q.
  - Next state:
    - lw/sw -> MEMADDR(2)
    - opcode 000000 with funct 001000 -> JR(13)
    - other 000000 -> EXEC_R(6)
    - addi/slti/sltiu/andi/ori/xori/lui -> EXEC_I(8)
    - beq/bne -> BRANCH(10)
    - j -> JUMP(11)
    - jal -> JAL(12)
    - anything else -> FETCH, retired as a NOP.
- MEMADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=0000. Next: MEMREAD(3) for lw, MEMWRITE(5) for sw.
- MEMREAD(3): MemRead=1, IorD=1. Hold until mem_ready, then go to MEMWB(4).
- MEMWB(4): RegWrite=1, RegDst=00, WBSel=01. Go to FETCH.
- MEMWRITE(5): MemWrite=1, IorD=1. Hold until mem_ready, then go to FETCH.
- EXEC_R(6): ALUSrcA=1, ALUSrcB=00, ALUOp=0010. Go to RWB(7).
- RWB(7): RegWrite=1, RegDst=01, WBSel=00. Go to FETCH.
- EXEC_I(8): ALUSrcA=1, ALUSrcB=10.
  - ALUOp: addi 0000, slti 0011, sltiu 1000, andi 0100, ori 0101, xori 0110, lui 0111.
  - isSigned=0 for andi/ori/xori/lui.
  - Go to IWB(9).
- IWB(9): RegWrite=1, RegDst=00, WBSel=00. Go to FETCH.
- BRANCH(10): ALUSrcA=1, ALUSrcB=00, ALUOp=0001, PCSource=01.
  - PCWrite = zero for beq, ~zero for bne.
  - Go to FETCH.
- JUMP(11): PCWrite=1, PCSource=10. Go to FETCH.
- JAL(12): PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, WBSel=10.
  - The register file captures the pre-update PC (= PC+4) on the same edge that loads the jump target.
  - Go to FETCH.
- JR(13): PCWrite=1, PCSource=11. Go to FETCH.
- InstrCount:
  - Increments by 1 on each edge that returns to FETCH from a completing state.
  - Completing states: MEMWB, MEMWRITE (with mem_ready), RWB, IWB, BRANCH, JUMP, JAL, JR, and the DECODE NOP path.
  - Wraps at 2^CNT_W - 1 -> 0.
- Zero-wait cycle counts (mem_ready held 1): R/I-type 4, lw 5, sw 4, beq/bne/j/jal/jr 3.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Unused encodings 14-15 -> FETCH next cycle, all strobes 0.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - An undecoded opcode in DECODE goes to TRAP(14), not FETCH, and InstrCount does not increment.
  - In TRAP: Trap=1, all strobes 0. Only rst_n low exits.
- Undefined:
  - No TRAP state; undecoded opcodes retire as NOPs.
  - Trap is tied to 0.

Test Plan:
- Reset with mem_ready=1, opcode=000000, funct=100000 -> states 0,1,6,7,0; RegWrite=1 only in state 7 with RegDst=01; InstrCount 0->1.
- lw (100011) with mem_ready low for 3 cycles in MEMREAD -> state 3 held 4 cycles with MemRead=1, IorD=1; then MEMWB with WBSel=01; 8 cycles total.
- beq with zero=1, then bne with zero=1 -> PCWrite=1 in state 10 for beq, 0 for bne; PCSource=01 both; InstrCount +2.
- jal -> state 12 with PCWrite=1, RegWrite=1, RegDst=10, WBSel=10, PCSource=10. Then opcode 000000 with funct 001000 -> state 13, PCSource=11.
- andi (001100) -> state 8 with ALUOp=0100, isSigned=0; slti -> ALUOp=0011, isSigned=1.
- rst_n low mid-MEMWRITE -> MemWrite drops 0 immediately, State=0, InstrCount=0. Opcode 111111 -> Trap=1, state 14 held (macro defined), or NOP retire with InstrCount+1 (undefined).
